// File: rtl/arm_dp_encoder.sv
// -----------------------------------------------------------------------------
// arm_dp_encoder
//
// Sequential ARM data-processing instruction encoder (inverse of the decoder).
// Accepts decoded fields over a valid/ready handshake, assembles the 32-bit
// instruction word and presents it on a valid/ready output handshake.
//
// Immediate operands (op2_kind 00) need a rotate_imm/immed_8 pair. By default
// the search tests one rotation per cycle, lowest rotation first, so the first
// hit is the canonical encoding. With ARM_ENC_FAST_IMM_EN defined, all 16
// rotations are tested in one cycle with a lowest-rotation priority pick and
// the rotation counter is not built.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   cond, opcode, s_bit condition, ALU opcode, set-flags request
//   rn, rd, rm, rs      register numbers
//   op2_kind            00 imm32, 01 Rm imm shift, 10 Rm reg shift, 11 illegal
//   imm32               immediate value to encode
//   shift_type/amt      shift type and immediate shift amount
//   out_valid/out_ready result handshake
//   out_inst            encoded instruction (0 on error)
//   out_err             operand cannot be encoded
// -----------------------------------------------------------------------------
module arm_dp_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [3:0]  rm,
  input  logic [3:0]  rs,
  input  logic [1:0]  op2_kind,
  input  logic [31:0] imm32,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_OUT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cond_reg, opcode_reg, rn_reg, rd_reg, rm_reg, rs_reg;
  logic        s_reg;
  logic [1:0]  kind_reg, shift_type_reg;
  logic [4:0]  shift_amt_reg;
  logic [31:0] imm_reg;
  logic [31:0] inst_reg, inst_next;
  logic        err_reg, err_next;

  // Immediate search result for the current cycle
  logic        imm_hit;
  logic [3:0]  imm_rot;
  logic [7:0]  imm_byte;
  logic        imm_exhausted;

`ifdef ARM_ENC_FAST_IMM_EN
  logic [31:0] rot_all [16];
  logic [15:0] hit_vec;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    if (gi == 0) begin : g_zero
      assign rot_all[gi] = imm_reg;
    end else begin : g_nz
      assign rot_all[gi] = {imm_reg[31-2*gi:0], imm_reg[31:32-2*gi]};
    end
    assign hit_vec[gi] = (rot_all[gi][31:8] == 24'd0);
  end

  // Descending scan so the lowest matching rotation is the one left standing
  always_comb begin
    imm_hit  = 1'b0;
    imm_rot  = 4'd0;
    imm_byte = 8'd0;
    for (int i = 15; i >= 0; i--) begin
      if (hit_vec[i]) begin
        imm_hit  = 1'b1;
        imm_rot  = i[3:0];
        imm_byte = rot_all[i][7:0];
      end
    end
  end

  assign imm_exhausted = 1'b1;
`else
  logic [3:0]  rot_reg, rot_next;
  logic [4:0]  rot_sh;
  logic [31:0] rot_val;

  // Rotate-left by 2r undoes the instruction's rotate-right by 2*rotate_imm.
  // A right shift by 32 yields 0, so r=0 degenerates cleanly to imm_reg.
  assign rot_sh        = {rot_reg, 1'b0};
  assign rot_val       = (imm_reg << rot_sh) | (imm_reg >> (6'd32 - {1'b0, rot_sh}));
  assign imm_hit       = (rot_val[31:8] == 24'd0);
  assign imm_rot       = rot_reg;
  assign imm_byte      = rot_val[7:0];
  assign imm_exhausted = (rot_reg == 4'd15);
`endif

  // Compare/test opcodes always set flags; MOV/MVN have no first operand
  logic        s_eff;
  logic [3:0]  rn_eff;
  logic [31:0] common;

  assign s_eff  = s_reg | (opcode_reg[3:2] == 2'b10);
  assign rn_eff = (opcode_reg[3:2] == 2'b11 && opcode_reg[0]) ? 4'd0 : rn_reg;
  assign common = {cond_reg, 2'b00, 1'b0, opcode_reg, s_eff, rn_eff, rd_reg, 12'd0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      inst_reg       <= 32'd0;
      err_reg        <= 1'b0;
      cond_reg       <= 4'd0;
      opcode_reg     <= 4'd0;
      s_reg          <= 1'b0;
      rn_reg         <= 4'd0;
      rd_reg         <= 4'd0;
      rm_reg         <= 4'd0;
      rs_reg         <= 4'd0;
      kind_reg       <= 2'd0;
      imm_reg        <= 32'd0;
      shift_type_reg <= 2'd0;
      shift_amt_reg  <= 5'd0;
`ifndef ARM_ENC_FAST_IMM_EN
      rot_reg        <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      err_reg   <= err_next;
`ifndef ARM_ENC_FAST_IMM_EN
      rot_reg   <= rot_next;
`endif
      if (state_reg == ST_IDLE && in_valid) begin
        cond_reg       <= cond;
        opcode_reg     <= opcode;
        s_reg          <= s_bit;
        rn_reg         <= rn;
        rd_reg         <= rd;
        rm_reg         <= rm;
        rs_reg         <= rs;
        kind_reg       <= op2_kind;
        imm_reg        <= imm32;
        shift_type_reg <= shift_type;
        shift_amt_reg  <= shift_amt;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    inst_next  = inst_reg;
    err_next   = err_reg;
`ifndef ARM_ENC_FAST_IMM_EN
    rot_next   = rot_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_BUSY;
`ifndef ARM_ENC_FAST_IMM_EN
          rot_next   = 4'd0;
`endif
        end
      end
      ST_BUSY: begin
        case (kind_reg)
          2'b01: begin
            state_next = ST_OUT;
            err_next   = 1'b0;
            inst_next  = common | {20'd0, shift_amt_reg, shift_type_reg, 1'b0, rm_reg};
          end
          2'b10: begin
            state_next = ST_OUT;
            err_next   = 1'b0;
            inst_next  = common | {20'd0, rs_reg, 1'b0, shift_type_reg, 1'b1, rm_reg};
          end
          2'b11: begin
            state_next = ST_OUT;
            err_next   = 1'b1;
            inst_next  = 32'd0;
          end
          default: begin
            if (imm_hit) begin
              state_next = ST_OUT;
              err_next   = 1'b0;
              inst_next  = common | {6'd0, 1'b1, 13'd0, imm_rot, imm_byte};
            end else if (imm_exhausted) begin
              state_next = ST_OUT;
              err_next   = 1'b1;
              inst_next  = 32'd0;
            end else begin
`ifndef ARM_ENC_FAST_IMM_EN
              rot_next   = rot_reg + 4'd1;
`endif
            end
          end
        endcase
      end
      ST_OUT: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_OUT);
  assign out_inst  = inst_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_arm_dp_encoder.sv
module tb_arm_dp_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = 4'd0, opcode = 4'd0, rn = 4'd0, rd = 4'd0, rm = 4'd0, rs = 4'd0;
  logic        s_bit = 1'b0;
  logic [1:0]  op2_kind = 2'd0, shift_type = 2'd0;
  logic [31:0] imm32 = 32'd0;
  logic [4:0]  shift_amt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;

  int passed = 0;
  int total  = 0;

`ifdef ARM_ENC_FAST_IMM_EN
  localparam int K_ROT4 = 1;
  localparam int K_ROT15 = 1;
  localparam int K_MISS = 1;
`else
  localparam int K_ROT4 = 5;
  localparam int K_ROT15 = 16;
  localparam int K_MISS = 16;
`endif

  arm_dp_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .opcode(opcode), .s_bit(s_bit), .rn(rn), .rd(rd), .rm(rm), .rs(rs),
    .op2_kind(op2_kind), .imm32(imm32), .shift_type(shift_type), .shift_amt(shift_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Drive one request at a negedge; returns 1 time unit after the accept edge.
  task automatic accept(input logic [3:0] c, input logic [3:0] op, input logic s,
                        input logic [3:0] n, input logic [3:0] d, input logic [3:0] m,
                        input logic [3:0] sr, input logic [1:0] kind, input logic [31:0] imm,
                        input logic [1:0] st, input logic [4:0] sa);
    @(negedge clk);
    cond = c; opcode = op; s_bit = s; rn = n; rd = d; rm = m; rs = sr;
    op2_kind = kind; imm32 = imm; shift_type = st; shift_amt = sa;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Accept then count edges until out_valid; k = -1 if it never arrives.
  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] n, input logic [3:0] d, input logic [3:0] m,
                       input logic [3:0] sr, input logic [1:0] kind, input logic [31:0] imm,
                       input logic [1:0] st, input logic [4:0] sa, output int k);
    accept(c, op, s, n, d, m, sr, kind, imm, st, sa);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    $display("txn kind=%0d imm=%h inst=%h err=%b k=%0d", kind, imm, out_inst, out_err, k);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_inst !== 32'd0) $display("FAIL reset_out_inst got=%h exp=00000000", out_inst); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", out_err); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_imm_r0();
    int k;
    issue(4'hE, 4'b1101, 1'b0, 4'd7, 4'd1, 4'd0, 4'd0, 2'b00, 32'h0000_00FF, 2'd0, 5'd0, k);
    total++; if (out_inst !== 32'hE3A010FF) $display("FAIL imm_r0_inst got=%h exp=E3A010FF", out_inst); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL imm_r0_err got=%b exp=0", out_err); else passed++;
    total++; if (k !== 1) $display("FAIL imm_r0_latency got=%0d exp=1", k); else passed++;
    release_out();
    total++; if (in_ready !== 1'b1) $display("FAIL imm_r0_idle got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_imm_r4();
    int k;
    issue(4'hE, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2'b00, 32'hFF00_0000, 2'd0, 5'd0, k);
    total++; if (out_inst !== 32'hE3A014FF) $display("FAIL imm_r4_inst got=%h exp=E3A014FF", out_inst); else passed++;
    total++; if (k !== K_ROT4) $display("FAIL imm_r4_latency got=%0d exp=%0d", k, K_ROT4); else passed++;
    release_out();
  endtask

  task automatic test_imm_r15();
    int k;
    issue(4'hE, 4'b1101, 1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0000_03FC, 2'd0, 5'd0, k);
    total++; if (out_inst !== 32'hE3A00FFF) $display("FAIL imm_r15_inst got=%h exp=E3A00FFF", out_inst); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL imm_r15_err got=%b exp=0", out_err); else passed++;
    total++; if (k !== K_ROT15) $display("FAIL imm_r15_latency got=%0d exp=%0d", k, K_ROT15); else passed++;
    release_out();
  endtask

  task automatic test_imm_miss();
    int k;
    issue(4'hE, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2'b00, 32'h0000_0101, 2'd0, 5'd0, k);
    total++; if (out_err !== 1'b1) $display("FAIL imm_miss_err got=%b exp=1", out_err); else passed++;
    total++; if (out_inst !== 32'd0) $display("FAIL imm_miss_inst got=%h exp=00000000", out_inst); else passed++;
    total++; if (k !== K_MISS) $display("FAIL imm_miss_latency got=%0d exp=%0d", k, K_MISS); else passed++;
    release_out();
  endtask

  task automatic test_reg_shift();
    int k;
    issue(4'hE, 4'b0100, 1'b0, 4'd3, 4'd2, 4'd4, 4'd5, 2'b10, 32'd0, 2'b00, 5'd0, k);
    total++; if (out_inst !== 32'hE0832514) $display("FAIL reg_shift_inst got=%h exp=E0832514", out_inst); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL reg_shift_err got=%b exp=0", out_err); else passed++;
    total++; if (k !== 1) $display("FAIL reg_shift_latency got=%0d exp=1", k); else passed++;
    release_out();
  endtask

  task automatic test_illegal();
    int k;
    issue(4'hE, 4'b0100, 1'b0, 4'd3, 4'd2, 4'd4, 4'd5, 2'b11, 32'd0, 2'b00, 5'd0, k);
    total++; if (out_err !== 1'b1) $display("FAIL illegal_err got=%b exp=1", out_err); else passed++;
    total++; if (out_inst !== 32'd0) $display("FAIL illegal_inst got=%h exp=00000000", out_inst); else passed++;
    total++; if (k !== 1) $display("FAIL illegal_latency got=%0d exp=1", k); else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    int k;
    issue(4'hE, 4'b1010, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 2'b01, 32'd0, 2'b00, 5'd0, k);
    total++; if (k !== 1) $display("FAIL cmp_latency got=%0d exp=1", k); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_inst !== 32'hE1500001) $display("FAIL cmp_hold_inst cyc=%0d got=%h exp=E1500001", i, out_inst); else passed++;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL cmp_hold_hs cyc=%0d got in_ready=%b out_valid=%b exp 0/1", i, in_ready, out_valid); else passed++;
      @(posedge clk);
      #1;
    end
    release_out();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL cmp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int k;
    issue(4'h0, 4'b0001, 1'b1, 4'd2, 4'd3, 4'd4, 4'd0, 2'b01, 32'd0, 2'b10, 5'd31, k);
    total++; if (out_inst !== 32'h00323FC4) $display("FAIL b2b_first_inst got=%h exp=00323FC4", out_inst); else passed++;
    release_out();
    issue(4'hE, 4'b0100, 1'b0, 4'd3, 4'd2, 4'd4, 4'd5, 2'b10, 32'd0, 2'b00, 5'd0, k);
    total++; if (out_inst !== 32'hE0832514 || k !== 1)
      $display("FAIL b2b_second got inst=%h k=%0d exp E0832514 k=1", out_inst, k); else passed++;
    release_out();
  endtask

  task automatic test_reset_midsearch();
    int seen;
    accept(4'hE, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2'b00, 32'h0000_0101, 2'd0, 5'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", out_valid); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_reset_ready got=%b exp=1", in_ready); else passed++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || out_err !== 1'b0 || out_inst !== 32'd0) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_reset_stale got=%0d bad cycles exp=0", seen); else passed++;
  endtask

  task automatic test_reset_in_out();
    int k;
    issue(4'hE, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2'b00, 32'h0000_00FF, 2'd0, 5'd0, k);
    total++; if (out_valid !== 1'b1) $display("FAIL out_reset_pre got=%b exp=1", out_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_inst !== 32'd0)
      $display("FAIL out_reset_async got valid=%b inst=%h exp 0/00000000", out_valid, out_inst); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL out_reset_ready got=%b exp=1", in_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_imm_r0();
    test_imm_r4();
    test_imm_r15();
    test_imm_miss();
    test_reg_shift();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midsearch();
    test_reset_in_out();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
